spdif_channel_status_sequencer: RTL and testbench
=================================================

Name: spdif_channel_status_sequencer

Overview:
Parametrised successor to the static consumer channel-status layout. It holds the 192-bit channel-status word internally and emits one channel-status bit per channel each audio frame, with block-start and bit-index markers, for the S/PDIF and HDMI subframe builders. It adds multi-channel number insertion, a professional mode with a serially computed CRCC, and a block-synchronous configuration shadow, so fields never change mid-block.

Parameters:
NUM_CHANNELS, 2, number of channels served (1..8).
CHANNEL_NUM_BASE, 1, channel number for channel 0. 0 means no channel numbers are inserted. Requires CHANNEL_NUM_BASE+NUM_CHANNELS-1 <= 15.

Ports:
clk  input  1  system clock
resetN  input  1  asynchronous active-low reset
frameStrobe  input  1  one-cycle pulse; advances one frame (one status bit)
syncBlock  input  1  forces the next emitted bit to be index 0
professional  input  1  0 = consumer layout, 1 = professional layout with CRCC
copyPermit  input  1  consumer bit 2
categoryCode  input  8  consumer bits 15:8
samplingFreq  input  4  consumer bits 27:24; mapped to professional bits 7:6
wordLength  input  4  bits 35:32 (consumer) or bits 19:16 (professional)
csBits  output  NUM_CHANNELS  channel-status bit for each channel for this frame
bitIndex  output  8  index (0..191) of the bit on csBits
blockStart  output  1  high while bitIndex==0
csValid  output  1  one-cycle pulse when csBits, bitIndex and blockStart update

Behaviour:
- Reset (async assert, sync release): csBits=0, bitIndex=0, blockStart=0, csValid=0, internal next index=0, shadow config=0, CRC register=8'hFF.
- Latency: frameStrobe in cycle t updates outputs in cycle t+1. csValid is high only in t+1. Outputs hold between strobes.
- Index: emitted index = next index. Next index becomes 0 after 191, otherwise it increments by 1.
- syncBlock with or without frameStrobe: emitted index = 0 and next index = 1. syncBlock alone produces an emission, the same as a strobe. syncBlock has priority over the normal index sequence.
- Shadow config: captured from the live inputs in the cycle that emits index 0. Bit 0 uses the live inputs. Bits 1..191 use the shadow. Input changes mid-block have no effect until the next block.
- Consumer layout (professional=0):
  - bit0=0, bit1=0, bit2=copyPermit, bits5:3=0, bits7:6=0.
  - bits15:8=categoryCode, bits19:16=0.
  - bits23:20 for channel c = CHANNEL_NUM_BASE+c (4-bit), or 0 when CHANNEL_NUM_BASE==0.
  - bits27:24=samplingFreq, bits31:28=0, bits35:32=wordLength, bits191:36=0.
- Professional layout (professional=1), identical on all channels:
  - bit0=1, bits5:1=0.
  - bits7:6 from samplingFreq: 4'd2→2'b01 (bit6=1), 4'd0→2'b10, 4'd3→2'b11, otherwise 2'b00.
  - bits15:8=0, bits19:16=wordLength, bits183:20=0, bits191:184=CRCC.
- CRCC:
  - Generator x^8+x^4+x^3+x^2+1.
  - Register set to 8'hFF when index 0 is emitted, then updated with each emitted bit 0..183 in order.
  - Per-bit update: fb = d ^ c[7]; c = {c[6:0],1'b0} ^ (fb ? 8'h1D : 8'h00).
  - Bit 184+k emits c[7-k]. The register is frozen during indices 184..191.
  - In consumer mode the CRC still runs but is unused.
- Wrap: after index 191 the next strobe emits index 0, sets blockStart=1, relatches the shadow and resets the CRC.
- Reset mid-block: all state returns to reset values. The first strobe after release emits index 0.

Test Plan:
- Consumer, NUM_CHANNELS=2, base 1, categoryCode=8'h99, samplingFreq=2, wordLength=2, copyPermit=1, 192 strobes:
  - csBits=2'b11 at indices 2, 8, 11, 12, 15, 25 and 33.
  - csBits=2'b01 (ch0) at index 20 and 2'b10 (ch1) at index 21.
  - csBits=0 at all other indices.
  - blockStart only at index 0.
- Latency/hold: single strobe at cycle 10 → outputs change and csValid=1 at cycle 11 only. No change in cycles 12..20 without a strobe.
- Mid-block change: categoryCode 8'h99→8'h00 at index 50 → current block unchanged. Next block indices 8, 11, 12 and 15 read 0.
- syncBlock at index 100 together with frameStrobe → emitted bitIndex=0 and blockStart=1, then 1, 2, … on later strobes. A wrap 191→0 occurs without syncBlock.
- Professional, samplingFreq=2, wordLength=4'hB: bit0=1, bit6=1, bit7=0, bits19:16=4'hB. Bits 184..191 match the bench CRC model over bits 0..183 for two consecutive blocks.
- Reset asserted at index 120 → all outputs 0 immediately. After release, the first strobe gives bitIndex=0, blockStart=1 and csValid=1.

Source files
------------

// File: rtl/spdif_channel_status_sequencer.sv
// rtl/spdif_channel_status_sequencer.sv - per-frame S/PDIF channel-status bit sequencer with block-synchronous config and CRCC
module spdif_channel_status_sequencer #(
   parameter int NUM_CHANNELS     = 2,
   parameter int CHANNEL_NUM_BASE = 1
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    frameStrobe,
   input  logic                    syncBlock,
   input  logic                    professional,
   input  logic                    copyPermit,
   input  logic [7:0]              categoryCode,
   input  logic [3:0]              samplingFreq,
   input  logic [3:0]              wordLength,
   output logic [NUM_CHANNELS-1:0] csBits,
   output logic [7:0]              bitIndex,
   output logic                    blockStart,
   output logic                    csValid
);

   localparam logic [7:0] IDX_LAST     = 8'd191;
   localparam logic [7:0] IDX_CRC_LAST = 8'd183;

   // one CRCC step, generator x^8+x^4+x^3+x^2+1, MSB first
   function automatic logic [7:0] crc_step(input logic [7:0] c, input logic d);
      logic fb;
      fb = d ^ c[7];
      return {c[6:0], 1'b0} ^ (fb ? 8'h1D : 8'h00);
   endfunction

   // value of status bit idx for one channel under the given configuration
   function automatic logic status_bit(
      input logic [7:0] idx,
      input logic       prof,
      input logic       cp,
      input logic [7:0] cat,
      input logic [3:0] sf,
      input logic [3:0] wl,
      input logic [3:0] chnum,
      input logic [7:0] crc
   );
      logic       b;
      logic [1:0] fs_code;
      b = 1'b0;
      case (sf)
         4'd2:    fs_code = 2'b01;
         4'd0:    fs_code = 2'b10;
         4'd3:    fs_code = 2'b11;
         default: fs_code = 2'b00;
      endcase
      if (prof) begin
         if (idx == 8'd0)                             b = 1'b1;
         else if (idx == 8'd6)                        b = fs_code[0];
         else if (idx == 8'd7)                        b = fs_code[1];
         else if (idx >= 8'd16 && idx <= 8'd19)       b = wl[idx[1:0]];
         else if (idx >= 8'd184)                      b = crc[3'd7 - idx[2:0]];
      end else begin
         if (idx == 8'd2)                             b = cp;
         else if (idx >= 8'd8 && idx <= 8'd15)        b = cat[idx[2:0]];
         else if (idx >= 8'd20 && idx <= 8'd23)       b = chnum[idx[1:0]];
         else if (idx >= 8'd24 && idx <= 8'd27)       b = sf[idx[1:0]];
         else if (idx >= 8'd32 && idx <= 8'd35)       b = wl[idx[1:0]];
      end
      return b;
   endfunction

   logic [NUM_CHANNELS-1:0] cs_q, cs_d;
   logic [7:0]              bit_index_q, bit_index_d;
   logic                    block_start_q, block_start_d;
   logic                    cs_valid_q, cs_valid_d;
   logic [7:0]              next_idx_q, next_idx_d;
   logic [7:0]              crc_q, crc_d;
   logic                    shd_prof_q, shd_prof_d;
   logic                    shd_cp_q, shd_cp_d;
   logic [7:0]              shd_cat_q, shd_cat_d;
   logic [3:0]              shd_sf_q, shd_sf_d;
   logic [3:0]              shd_wl_q, shd_wl_d;

   logic                    emit;
   logic [7:0]              emit_idx;
   logic                    use_live;
   logic                    cfg_prof, cfg_cp;
   logic [7:0]              cfg_cat;
   logic [3:0]              cfg_sf, cfg_wl;
   logic [3:0]              chnum;
   logic [NUM_CHANNELS-1:0] bits;

   // emission index, config selection, per-channel bits, CRC and shadow next state
   always_comb begin
      emit     = frameStrobe | syncBlock;
      emit_idx = syncBlock ? 8'd0 : next_idx_q;
      // the block's first bit sees the live inputs, which are also what the shadow captures
      use_live = (emit_idx == 8'd0);
      cfg_prof = use_live ? professional : shd_prof_q;
      cfg_cp   = use_live ? copyPermit   : shd_cp_q;
      cfg_cat  = use_live ? categoryCode : shd_cat_q;
      cfg_sf   = use_live ? samplingFreq : shd_sf_q;
      cfg_wl   = use_live ? wordLength   : shd_wl_q;

      bits  = '0;
      chnum = 4'd0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         chnum   = (CHANNEL_NUM_BASE == 0) ? 4'd0 : 4'(CHANNEL_NUM_BASE + c);
         bits[c] = status_bit(emit_idx, cfg_prof, cfg_cp, cfg_cat, cfg_sf, cfg_wl, chnum, crc_q);
      end

      cs_d          = cs_q;
      bit_index_d   = bit_index_q;
      block_start_d = block_start_q;
      cs_valid_d    = emit;
      next_idx_d    = next_idx_q;
      crc_d         = crc_q;
      shd_prof_d    = shd_prof_q;
      shd_cp_d      = shd_cp_q;
      shd_cat_d     = shd_cat_q;
      shd_sf_d      = shd_sf_q;
      shd_wl_d      = shd_wl_q;

      if (emit) begin
         cs_d          = bits;
         bit_index_d   = emit_idx;
         block_start_d = (emit_idx == 8'd0);
         next_idx_d    = (emit_idx == IDX_LAST) ? 8'd0 : emit_idx + 8'd1;
         // CRC restarts from all-ones at bit 0 and holds while its own bits go out;
         // channel 0 feeds it since professional bits are identical on every channel
         if (emit_idx == 8'd0)
            crc_d = crc_step(8'hFF, bits[0]);
         else if (emit_idx <= IDX_CRC_LAST)
            crc_d = crc_step(crc_q, bits[0]);
         if (emit_idx == 8'd0) begin
            shd_prof_d = professional;
            shd_cp_d   = copyPermit;
            shd_cat_d  = categoryCode;
            shd_sf_d   = samplingFreq;
            shd_wl_d   = wordLength;
         end
      end
   end

   // state register with asynchronous reset
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         cs_q          <= '0;
         bit_index_q   <= 8'd0;
         block_start_q <= 1'b0;
         cs_valid_q    <= 1'b0;
         next_idx_q    <= 8'd0;
         crc_q         <= 8'hFF;
         shd_prof_q    <= 1'b0;
         shd_cp_q      <= 1'b0;
         shd_cat_q     <= 8'd0;
         shd_sf_q      <= 4'd0;
         shd_wl_q      <= 4'd0;
      end else begin
         cs_q          <= cs_d;
         bit_index_q   <= bit_index_d;
         block_start_q <= block_start_d;
         cs_valid_q    <= cs_valid_d;
         next_idx_q    <= next_idx_d;
         crc_q         <= crc_d;
         shd_prof_q    <= shd_prof_d;
         shd_cp_q      <= shd_cp_d;
         shd_cat_q     <= shd_cat_d;
         shd_sf_q      <= shd_sf_d;
         shd_wl_q      <= shd_wl_d;
      end
   end

   assign csBits     = cs_q;
   assign bitIndex   = bit_index_q;
   assign blockStart = block_start_q;
   assign csValid    = cs_valid_q;

endmodule

// File: tb/tb_spdif_channel_status_sequencer.sv
// tb/tb_spdif_channel_status_sequencer.sv - scoreboard bench for the channel-status sequencer
module tb_spdif_channel_status_sequencer;

   localparam int NC   = 2;
   localparam int BASE = 1;

   logic          clk = 1'b0;
   logic          resetN = 1'b0;
   logic          frameStrobe = 1'b0;
   logic          syncBlock = 1'b0;
   logic          professional = 1'b0;
   logic          copyPermit = 1'b0;
   logic [7:0]    categoryCode = 8'd0;
   logic [3:0]    samplingFreq = 4'd0;
   logic [3:0]    wordLength = 4'd0;
   logic [NC-1:0] csBits;
   logic [7:0]    bitIndex;
   logic          blockStart;
   logic          csValid;

   spdif_channel_status_sequencer #(.NUM_CHANNELS(NC), .CHANNEL_NUM_BASE(BASE)) dut (
      .clk(clk), .resetN(resetN), .frameStrobe(frameStrobe), .syncBlock(syncBlock),
      .professional(professional), .copyPermit(copyPermit), .categoryCode(categoryCode),
      .samplingFreq(samplingFreq), .wordLength(wordLength),
      .csBits(csBits), .bitIndex(bitIndex), .blockStart(blockStart), .csValid(csValid)
   );

   always #5 clk = ~clk;

   int cnt = 0;
   always @(posedge clk) cnt++;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [NC-1:0] cs;
      logic [7:0]    idx;
      logic          bs;
      int            cyc;
   } exp_t;

   exp_t          q[$];
   int            m_idx = 0;
   logic [191:0]  blk [NC];

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // whole 192-bit block for one channel, built directly from the field layout
   function automatic logic [191:0] build_block(input int ch);
      logic [191:0] b;
      logic [7:0]   c;
      b = '0;
      if (professional) begin
         b[0] = 1'b1;
         case (samplingFreq)
            4'd2: b[7:6] = 2'b01;
            4'd0: b[7:6] = 2'b10;
            4'd3: b[7:6] = 2'b11;
            default: b[7:6] = 2'b00;
         endcase
         b[19:16] = wordLength;
         c = 8'hFF;
         for (int i = 0; i < 184; i++) begin
            if (b[i] ^ c[7]) c = {c[6:0], 1'b0} ^ 8'h1D;
            else             c = {c[6:0], 1'b0};
         end
         for (int k = 0; k < 8; k++) b[184+k] = c[7-k];
      end else begin
         b[2]     = copyPermit;
         b[15:8]  = categoryCode;
         if (BASE != 0) b[23:20] = 4'(BASE + ch);
         b[27:24] = samplingFreq;
         b[35:32] = wordLength;
      end
      return b;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // issue one emission (strobe and/or sync) and queue what it must produce
   task automatic emit(input bit strobe, input bit sync);
      exp_t e;
      if (sync) m_idx = 0;
      if (m_idx == 0)
         for (int ch = 0; ch < NC; ch++) blk[ch] = build_block(ch);
      for (int ch = 0; ch < NC; ch++) e.cs[ch] = blk[ch][m_idx];
      e.idx = 8'(m_idx);
      e.bs  = (m_idx == 0);
      e.cyc = cnt + 1;
      q.push_back(e);
      m_idx = (m_idx == 191) ? 0 : m_idx + 1;
      frameStrobe = strobe;
      syncBlock   = sync;
      @(posedge clk);
      #1;
      frameStrobe = 1'b0;
      syncBlock   = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         emit(1'b1, 1'b0);
         idle($urandom_range(0, 2));
      end
   endtask

   // monitor: reset values, scoreboard pop on csValid, hold between emissions
   logic [NC-1:0] last_cs = '0;
   logic [7:0]    last_idx = 8'd0;
   logic          last_bs = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!resetN) begin
         chk(csBits == '0 && bitIndex == 8'd0 && !blockStart && !csValid, "reset_outputs",
             {csBits, bitIndex, blockStart, csValid}, 0);
         last_cs = '0; last_idx = 8'd0; last_bs = 1'b0;
      end else if (csValid) begin
         if (q.size() == 0) begin
            chk(1'b0, "unexpected_csValid", bitIndex, -1);
         end else begin
            e = q.pop_front();
            chk(csBits == e.cs, "csBits", csBits, e.cs);
            chk(bitIndex == e.idx, "bitIndex", bitIndex, e.idx);
            chk(blockStart == e.bs, "blockStart", blockStart, e.bs);
            chk(cnt == e.cyc, "latency_cycle", cnt, e.cyc);
            last_cs = e.cs; last_idx = e.idx; last_bs = e.bs;
         end
      end else begin
         chk(csBits == last_cs && bitIndex == last_idx && blockStart == last_bs, "hold",
             {csBits, bitIndex, blockStart}, {last_cs, last_idx, last_bs});
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      idle(3);
      resetN = 1'b1;
      idle(2);

      // consumer directed block, then a category change at index 50
      professional = 1'b0; copyPermit = 1'b1; categoryCode = 8'h99;
      samplingFreq = 4'd2; wordLength = 4'd2;
      run(192);
      run(50);
      categoryCode = 8'h00;
      run(142);
      run(192);

      // latency and hold: a lone strobe, then quiet cycles
      idle(4);
      emit(1'b1, 1'b0);
      idle(10);

      // sync with strobe at index 100, continue through a natural wrap
      run(100 - m_idx);
      emit(1'b1, 1'b1);
      run(200);
      // sync alone also emits
      idle(2);
      emit(1'b0, 1'b1);
      run(5);

      // professional, two consecutive blocks
      professional = 1'b1; samplingFreq = 4'd2; wordLength = 4'hB;
      emit(1'b1, 1'b1);
      run(191);
      run(192);

      // randomized configurations, changed mid-block
      for (int b = 0; b < 4; b++) begin
         professional = 1'($urandom); copyPermit = 1'($urandom);
         categoryCode = 8'($urandom); samplingFreq = 4'($urandom); wordLength = 4'($urandom);
         emit(1'b1, 1'b1);
         run($urandom_range(10, 150));
         professional = 1'($urandom); categoryCode = 8'($urandom);
         samplingFreq = 4'($urandom); wordLength = 4'($urandom);
         run(192 - m_idx);
      end

      // reset at index 120
      professional = 1'b0; categoryCode = 8'h99; samplingFreq = 4'd2; wordLength = 4'd2;
      emit(1'b1, 1'b1);
      run(119);
      idle(1);
      resetN = 1'b0;
      #1;
      chk(csBits == '0 && bitIndex == 8'd0 && !blockStart && !csValid, "async_reset",
          {csBits, bitIndex, blockStart, csValid}, 0);
      q.delete();
      m_idx = 0;
      idle(3);
      resetN = 1'b1;
      idle(2);
      emit(1'b1, 1'b0);
      run(20);

      idle(5);
      chk(q.size() == 0, "queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
